// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the CPU-side UART register block / transmitter and the
// transmit FIFO. The master drives the push, flush and clear strobes and the
// transmitter busy line. The slave is the FIFO, which returns the launch strobe,
// the byte being sent and the status fields.
interface uart_tx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              flush;
   logic              ovf_clr;
   logic              tx_busy;
   logic              tx_en;
   logic [7:0]        tx_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   level;
   logic              overflow;

   modport master (
      output wr_en, wr_data, flush, ovf_clr, tx_busy,
      input  tx_en, tx_data, full, empty, level, overflow
   );

   modport slave (
      input  wr_en, wr_data, flush, ovf_clr, tx_busy,
      output tx_en, tx_data, full, empty, level, overflow
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO for the CPU UART. Data-register writes are pushed at bus speed.
// A small launcher FSM drains one byte per frame into the transmitter using its
// enable/busy handshake. It also provides full/empty/level/overflow for status.
module uart_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   C_LVL_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
   localparam logic [1:0]        C_TO_ONE  = 2'd1;
   localparam logic [1:0]        C_TO_LAST = 2'd2;

   // Pointers wrap naturally at ADDR_W bits, so DEPTH has to be 2**ADDR_W.
   if (DEPTH < 2 || (1 << ADDR_W) != DEPTH) begin : g_param_check
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
   end

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic              r_overflow;
   state_t            r_state;
   logic [1:0]        r_to_cnt;
   logic              r_tx_en;
   logic [7:0]        r_tx_data;

   logic              w_full;
   logic              w_empty;
   logic              w_wr_req;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [1:0]        w_to_nxt;

   assign w_full   = (r_level == C_DEPTH);
   assign w_empty  = (r_level == '0);

   // A flush discards a same-cycle write outright. That write is neither
   // stored nor counted as an overflow.
   assign w_wr_req = bus.wr_en && !bus.flush;

   // The only pop is the IDLE->LAUNCH edge. Flush suppresses it so that the
   // FSM stays in IDLE on an emptied FIFO.
   assign w_pop    = (r_state == S_IDLE) && !w_empty && !bus.tx_busy && !bus.flush;

   // A full FIFO still accepts a write when the same edge frees a slot.
   assign w_push   = w_wr_req && (!w_full || w_pop);
   assign w_drop   = w_wr_req && w_full && !w_pop;

   assign w_to_nxt = r_to_cnt + C_TO_ONE;

   // Storage array: write-only port. The read happens in the launcher.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.wr_data;
      end
   end

   // Write pointer, occupancy counter and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (bus.flush) begin
            r_wr_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
               r_level <= r_level + C_LVL_ONE;
            end else if (w_pop && !w_push) begin
               r_level <= r_level - C_LVL_ONE;
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Launcher FSM. It owns the read pointer and registers tx_en and tx_data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_to_cnt  <= '0;
         r_rd_ptr  <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
      end else begin
         r_tx_en <= 1'b0;
         if (bus.flush) begin
            r_rd_ptr <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_tx_data <= r_mem[r_rd_ptr];
                  r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
                  r_tx_en   <= 1'b1;
                  r_state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               r_to_cnt <= '0;
               r_state  <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // Give up after two quiet cycles: the transmitter either
               // finished already or ignored the strobe.
               if (bus.tx_busy) begin
                  r_state <= S_WAIT_DONE;
               end else begin
                  r_to_cnt <= w_to_nxt;
                  if (w_to_nxt == C_TO_LAST) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_en    = r_tx_en;
   assign bus.tx_data  = r_tx_data;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.level    = r_level;
   assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. It uses a directed vector table for the
// cycle-by-cycle handshake and hand-written sequences for the long multi-frame
// cases. A simple transmitter model raises busy for FRAME cycles after each
// launch.
module tb_uart_tx_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int FRAME  = 100;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   logic model_en = 1'b0;
   logic force_busy = 1'b0;
   int   busy_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: a launch seen at an edge makes busy high for FRAME cycles.
   always @(posedge clk) begin
      if (model_en && bus.tx_en) busy_cnt <= FRAME;
      else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
   end

   assign bus.tx_busy = force_busy | (busy_cnt != 0);

   // Launch monitor: records every tx_en and checks the strobe rules.
   logic [7:0] cap_d [128];
   int         cap_t [128];
   int         n_launch = 0;
   logic       prev_en  = 1'b0;

   always @(negedge clk) begin
      if (bus.tx_en === 1'b1) begin
         if (n_launch < 128) begin
            cap_d[n_launch] = bus.tx_data;
            cap_t[n_launch] = cyc;
         end
         n_launch++;
         checks++;
         if (prev_en) begin
            errors++;
            $display("FAIL tx_en_consecutive got 1 exp 0 at cycle %0d", cyc);
         end
         checks++;
         if (bus.tx_busy) begin
            errors++;
            $display("FAIL tx_en_while_busy got 1 exp 0 at cycle %0d", cyc);
         end
      end
      prev_en = (bus.tx_en === 1'b1);
   end

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       fl;
      logic       oc;
      logic       bsy;
      logic [4:0] lvl;
      logic       emp;
      logic       ful;
      logic       ten;
      logic [7:0] td;
      logic       ovf;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic fl,
                               input logic oc, input logic bsy, input logic [4:0] lvl,
                               input logic emp, input logic ful, input logic ten,
                               input logic [7:0] td, input logic ovf);
      vec_t v;
      v.wr = wr; v.d = d; v.fl = fl; v.oc = oc; v.bsy = bsy;
      v.lvl = lvl; v.emp = emp; v.ful = ful; v.ten = ten; v.td = td; v.ovf = ovf;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   task automatic chk_all(input string p, input logic [4:0] lvl, input logic emp,
                          input logic ful, input logic ten, input logic [7:0] td,
                          input logic ovf);
      chk({p, "_level"},    32'(bus.level),    32'(lvl));
      chk({p, "_empty"},    32'(bus.empty),    32'(emp));
      chk({p, "_full"},     32'(bus.full),     32'(ful));
      chk({p, "_tx_en"},    32'(bus.tx_en),    32'(ten));
      chk({p, "_tx_data"},  32'(bus.tx_data),  32'(td));
      chk({p, "_overflow"}, 32'(bus.overflow), 32'(ovf));
   endtask

   task automatic idle_inputs();
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.flush   = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic write(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   int base;
   int c0;

   initial begin
      idle_inputs();
      do_reset();

      // wr  data  fl oc bsy | lvl emp ful ten tx_data ovf
      tbl[0]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 8'h00, 0);
      tbl[1]  = mk(1, 8'h41, 0, 0, 0,  1, 0, 0, 0, 8'h00, 0);
      tbl[2]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 1, 8'h41, 0);
      tbl[3]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 8'h41, 0);
      tbl[4]  = mk(1, 8'h42, 0, 0, 1,  1, 0, 0, 0, 8'h41, 0);
      tbl[5]  = mk(1, 8'h43, 0, 0, 1,  2, 0, 0, 0, 8'h41, 0);
      tbl[6]  = mk(0, 8'h00, 0, 0, 0,  2, 0, 0, 0, 8'h41, 0);
      tbl[7]  = mk(0, 8'h00, 0, 0, 1,  2, 0, 0, 0, 8'h41, 0);
      tbl[8]  = mk(0, 8'h00, 0, 1, 0,  1, 0, 0, 1, 8'h42, 0);
      tbl[9]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 8'h42, 0);
      tbl[10] = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 8'h42, 0);
      tbl[11] = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 8'h42, 0);
      tbl[12] = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 1, 8'h43, 0);
      tbl[13] = mk(1, 8'h55, 1, 0, 0,  0, 1, 0, 0, 8'h43, 0);
      tbl[14] = mk(1, 8'h66, 0, 0, 0,  1, 0, 0, 0, 8'h43, 0);
      tbl[15] = mk(0, 8'h00, 1, 0, 0,  0, 1, 0, 0, 8'h43, 0);
      tbl[16] = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 8'h43, 0);
      tbl[17] = mk(1, 8'h77, 0, 0, 0,  1, 0, 0, 0, 8'h43, 0);
      tbl[18] = mk(0, 8'h00, 1, 0, 0,  0, 1, 0, 0, 8'h43, 0);
      tbl[19] = mk(0, 8'h00, 0, 0, 0,  0, 1, 0, 0, 8'h43, 0);

      model_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.wr_en   = tbl[i].wr;
         bus.wr_data = tbl[i].d;
         bus.flush   = tbl[i].fl;
         bus.ovf_clr = tbl[i].oc;
         force_busy  = tbl[i].bsy;
         step();
         chk_all($sformatf("row%0d", i), tbl[i].lvl, tbl[i].emp, tbl[i].ful,
                 tbl[i].ten, tbl[i].td, tbl[i].ovf);
      end
      idle_inputs();
      force_busy = 1'b0;

      // Fill to full behind a busy transmitter, overflow, then push on the pop edge.
      do_reset();
      model_en   = 1'b1;
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         write(8'(i));
         chk($sformatf("A_fill%0d_level", i), 32'(bus.level), 32'(i + 1));
         chk($sformatf("A_fill%0d_full", i), 32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
      end
      write(8'hEE);
      chk("A_drop_level", 32'(bus.level), 32'd16);
      chk("A_drop_overflow", 32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      chk("A_clr_overflow", 32'(bus.overflow), 32'd0);
      base        = n_launch;
      force_busy  = 1'b0;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hAA;
      step();
      bus.wr_en   = 1'b0;
      chk_all("A_popwr", 5'd16, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 4000 && n_launch < base + 17; k++) step();
      chk("A_launch_count", 32'(n_launch - base), 32'd17);
      for (int i = 0; i < 17 && base + i < n_launch; i++) begin
         chk($sformatf("A_byte%0d", i), 32'(cap_d[base + i]), (i < 16) ? 32'(i) : 32'hAA);
         if (i > 0)
            chk($sformatf("A_gap%0d", i), 32'(cap_t[base + i] - cap_t[base + i - 1]),
                32'(FRAME + 3));
      end
      chk("A_end_overflow", 32'(bus.overflow), 32'd0);
      repeat (FRAME + 20) step();

      // Transmitter that never goes busy: timeout path paces launches.
      do_reset();
      model_en = 1'b0;
      base     = n_launch;
      c0       = cyc;
      for (int i = 0; i < 4; i++) write(8'h10 + 8'(i));
      for (int k = 0; k < 100 && n_launch < base + 4; k++) step();
      chk("B_launch_count", 32'(n_launch - base), 32'd4);
      if (n_launch >= base + 4) begin
         chk("B_latency", 32'(cap_t[base] - c0), 32'd2);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("B_byte%0d", i), 32'(cap_d[base + i]), 32'h10 + 32'(i));
            if (i > 0)
               chk($sformatf("B_gap%0d", i), 32'(cap_t[base + i] - cap_t[base + i - 1]), 32'd4);
         end
      end
      repeat (10) step();
      chk("B_idle_count", 32'(n_launch - base), 32'd4);
      chk("B_idle_empty", 32'(bus.empty), 32'd1);

      // Flush mid-frame with a simultaneous write.
      do_reset();
      model_en = 1'b1;
      base     = n_launch;
      for (int i = 0; i < 6; i++) write(8'h20 + 8'(i));
      repeat (8) step();
      chk("C_pre_level", 32'(bus.level), 32'd5);
      chk("C_pre_busy", 32'(bus.tx_busy), 32'd1);
      chk("C_pre_tx_data", 32'(bus.tx_data), 32'h20);
      bus.flush   = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h99;
      step();
      idle_inputs();
      chk_all("C_flush", 5'd0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
      repeat (FRAME + 20) step();
      chk("C_post_count", 32'(n_launch - base), 32'd1);
      chk("C_post_busy", 32'(bus.tx_busy), 32'd0);
      chk_all("C_post", 5'd0, 1'b1, 1'b0, 1'b0, 8'h20, 1'b0);

      // Overflow priority over clear, then clear alone, then reset clears.
      do_reset();
      model_en   = 1'b0;
      force_busy = 1'b1;
      for (int i = 0; i < 16; i++) write(8'h80 + 8'(i));
      chk("D_full", 32'(bus.full), 32'd1);
      write(8'hEE);
      chk("D_ovf_set", 32'(bus.overflow), 32'd1);
      step();
      chk("D_ovf_sticky", 32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      write(8'hEF);
      bus.ovf_clr = 1'b0;
      chk("D_ovf_prio", 32'(bus.overflow), 32'd1);
      chk("D_ovf_prio_level", 32'(bus.level), 32'd16);
      bus.ovf_clr = 1'b1;
      step();
      bus.ovf_clr = 1'b0;
      chk("D_ovf_clr", 32'(bus.overflow), 32'd0);
      write(8'hF0);
      chk("D_ovf_again", 32'(bus.overflow), 32'd1);
      do_reset();
      chk_all("D_reset", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      force_busy = 1'b0;

      // Reset on the launch cycle; the next launch waits for the transmitter.
      model_en = 1'b1;
      base     = n_launch;
      write(8'h5B);
      step();
      chk("E_launch_en", 32'(bus.tx_en), 32'd1);
      chk("E_launch_data", 32'(bus.tx_data), 32'h5B);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_all("E_reset", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      write(8'h5A);
      repeat (20) step();
      chk("E_hold_level", 32'(bus.level), 32'd1);
      chk("E_hold_count", 32'(n_launch - base), 32'd1);
      chk("E_hold_busy", 32'(bus.tx_busy), 32'd1);
      for (int k = 0; k < 300 && n_launch < base + 2; k++) step();
      chk("E_final_count", 32'(n_launch - base), 32'd2);
      if (n_launch >= base + 2)
         chk("E_final_data", 32'(cap_d[base + 1]), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
